// File: rtl/multi_key_debouncer.sv
// Per-channel debouncer for mechanical keys and switches.
// Each channel: synchroniser chain, stability counter producing a clean level,
// registered press/release pulses and an optional auto-repeat generator.

module multi_key_debouncer #(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned SYNC_LENGTH   = 2,
  parameter int unsigned STABLE_CYCLES = 50000,
  parameter bit          INVERT        = 1'b1,
  parameter bit          REPEAT_EN     = 1'b0,
  parameter int unsigned REPEAT_DELAY  = 2500000,
  parameter int unsigned REPEAT_PERIOD = 500000
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] asyncIn,
  output logic [WIDTH-1:0] stateOut,
  output logic [WIDTH-1:0] pressPulse,
  output logic [WIDTH-1:0] releasePulse,
  output logic [WIDTH-1:0] repeatPulse
);

  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntTerm = CntW'(STABLE_CYCLES - 1);

  localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned RptW = $clog2(RptMax + 1);
  localparam logic [RptW-1:0] DelayTerm  = RptW'(REPEAT_DELAY - 1);
  localparam logic [RptW-1:0] PeriodTerm = RptW'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StRepeat
  } rptState_e;

  // Synchroniser stages; stage 0 captures the raw pins.
  logic [WIDTH-1:0] syncQ [SYNC_LENGTH];
  logic [WIDTH-1:0] syncLevel;

  // Shift raw inputs through the chain; reset loads the inactive raw level.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int k = 0; k < SYNC_LENGTH; k++) begin
        syncQ[k] <= {WIDTH{INVERT}};
      end
    end else begin
      syncQ[0] <= asyncIn;
      for (int k = 1; k < SYNC_LENGTH; k++) begin
        syncQ[k] <= syncQ[k-1];
      end
    end
  end

  // Polarity is applied only after the last flop so nothing precedes the chain.
  assign syncLevel = syncQ[SYNC_LENGTH-1] ^ {WIDTH{INVERT}};

  for (genvar g = 0; g < WIDTH; g++) begin : gChan
    logic [CntW-1:0] cntQ, cntD;
    logic            levelQ, levelD;
    logic            pressQ, pressD;
    logic            releaseQ, releaseD;

    // Count consecutive disagreeing samples; toggle the level at the terminal count.
    always_comb begin
      cntD     = '0;
      levelD   = levelQ;
      pressD   = 1'b0;
      releaseD = 1'b0;
      if (syncLevel[g] != levelQ) begin
        if (cntQ == CntTerm) begin
          levelD   = ~levelQ;
          pressD   = ~levelQ;
          releaseD = levelQ;
        end else begin
          cntD = cntQ + 1'b1;
        end
      end
    end

    // Debounce state and edge pulses.
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        cntQ     <= '0;
        levelQ   <= 1'b0;
        pressQ   <= 1'b0;
        releaseQ <= 1'b0;
      end else begin
        cntQ     <= cntD;
        levelQ   <= levelD;
        pressQ   <= pressD;
        releaseQ <= releaseD;
      end
    end

    assign stateOut[g]     = levelQ;
    assign pressPulse[g]   = pressQ;
    assign releasePulse[g] = releaseQ;

    if (REPEAT_EN) begin : gRpt
      rptState_e       stQ, stD;
      logic [RptW-1:0] rptCntQ, rptCntD;
      logic            rptQ, rptD;

      // Repeat FSM; keyed off the next level so a release wins over a due repeat.
      always_comb begin
        stD     = stQ;
        rptCntD = rptCntQ;
        rptD    = 1'b0;
        if (!levelD) begin
          stD     = StIdle;
          rptCntD = '0;
        end else begin
          case (stQ)
            StIdle: begin
              rptCntD = '0;
              if (pressD) begin
                stD = StWait;
              end
            end
            StWait: begin
              if (rptCntQ == DelayTerm) begin
                stD     = StRepeat;
                rptCntD = '0;
                rptD    = 1'b1;
              end else begin
                rptCntD = rptCntQ + 1'b1;
              end
            end
            StRepeat: begin
              if (rptCntQ == PeriodTerm) begin
                rptCntD = '0;
                rptD    = 1'b1;
              end else begin
                rptCntD = rptCntQ + 1'b1;
              end
            end
            default: begin
              stD     = StIdle;
              rptCntD = '0;
            end
          endcase
        end
      end

      // Repeat state, counter and registered pulse.
      always_ff @(posedge clock) begin
        if (!reset_n) begin
          stQ     <= StIdle;
          rptCntQ <= '0;
          rptQ    <= 1'b0;
        end else begin
          stQ     <= stD;
          rptCntQ <= rptCntD;
          rptQ    <= rptD;
        end
      end

      assign repeatPulse[g] = rptQ;
    end else begin : gNoRpt
      assign repeatPulse[g] = 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_key_debouncer.sv
// Directed bench for multi_key_debouncer with short debounce/repeat timing.

module tb_multi_key_debouncer;

  logic       clock;
  logic       reset_n;
  logic [3:0] asyncIn;
  logic [3:0] stateOut;
  logic [3:0] pressPulse;
  logic [3:0] releasePulse;
  logic [3:0] repeatPulse;

  int vectors;
  int miscompares;

  multi_key_debouncer #(
    .WIDTH        (4),
    .SYNC_LENGTH  (2),
    .STABLE_CYCLES(4),
    .INVERT       (1'b1),
    .REPEAT_EN    (1'b1),
    .REPEAT_DELAY (10),
    .REPEAT_PERIOD(3)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .asyncIn     (asyncIn),
    .stateOut    (stateOut),
    .pressPulse  (pressPulse),
    .releasePulse(releasePulse),
    .repeatPulse (repeatPulse)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [15:0] obs;
    reset_n = 1'b0;
    asyncIn = 4'b0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      obs = {stateOut, pressPulse, releasePulse, repeatPulse};
      vectors++;
      if (obs !== 16'h0000) begin
        $display("FAIL reset_hold cyc=%0d got=%h want=%h", k, obs, 16'h0000);
        miscompares++;
      end
    end
    reset_n = 1'b1;
    asyncIn = 4'hF;
    for (int k = 0; k < 10; k++) begin
      tick();
      obs = {stateOut, pressPulse, releasePulse, repeatPulse};
      vectors++;
      if (obs !== 16'h0000) begin
        $display("FAIL reset_idle cyc=%0d got=%h want=%h", k, obs, 16'h0000);
        miscompares++;
      end
    end
  endtask

  task automatic test_press_release();
    logic [15:0] obs, exp;
    asyncIn = 4'b1110;
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp = (k == 6) ? {4'b0001, 4'b0001, 4'b0000, 4'b0000} : 16'h0000;
      obs = {stateOut, pressPulse, releasePulse, repeatPulse};
      vectors++;
      if (obs !== exp) begin
        $display("FAIL press_latency k=%0d got=%h want=%h", k, obs, exp);
        miscompares++;
      end
    end
    asyncIn = 4'hF;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k < 6)       exp = {4'b0001, 4'b0000, 4'b0000, 4'b0000};
      else if (k == 6) exp = {4'b0000, 4'b0000, 4'b0001, 4'b0000};
      else             exp = 16'h0000;
      obs = {stateOut, pressPulse, releasePulse, repeatPulse};
      vectors++;
      if (obs !== exp) begin
        $display("FAIL release_latency k=%0d got=%h want=%h", k, obs, exp);
        miscompares++;
      end
    end
  endtask

  task automatic test_glitch();
    logic [15:0] obs;
    for (int r = 0; r < 10; r++) begin
      asyncIn = 4'b1101;
      for (int k = 0; k < 3; k++) begin
        tick();
        obs = {stateOut, pressPulse, releasePulse, repeatPulse};
        vectors++;
        if (obs !== 16'h0000) begin
          $display("FAIL glitch_low r=%0d k=%0d got=%h want=%h", r, k, obs, 16'h0000);
          miscompares++;
        end
      end
      asyncIn = 4'hF;
      for (int k = 0; k < 3; k++) begin
        tick();
        obs = {stateOut, pressPulse, releasePulse, repeatPulse};
        vectors++;
        if (obs !== 16'h0000) begin
          $display("FAIL glitch_high r=%0d k=%0d got=%h want=%h", r, k, obs, 16'h0000);
          miscompares++;
        end
      end
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      obs = {stateOut, pressPulse, releasePulse, repeatPulse};
      vectors++;
      if (obs !== 16'h0000) begin
        $display("FAIL glitch_settle k=%0d got=%h want=%h", k, obs, 16'h0000);
        miscompares++;
      end
    end
  endtask

  task automatic test_repeat();
    logic [15:0] obs, exp;
    logic [3:0]  st, rel, rep;
    asyncIn = 4'b1011;
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp = (k == 6) ? {4'b0100, 4'b0100, 4'b0000, 4'b0000} : 16'h0000;
      obs = {stateOut, pressPulse, releasePulse, repeatPulse};
      vectors++;
      if (obs !== exp) begin
        $display("FAIL repeat_press k=%0d got=%h want=%h", k, obs, exp);
        miscompares++;
      end
    end
    // Release driven after press+25 lands at press+31, where a repeat is also due.
    for (int t = 1; t <= 34; t++) begin
      tick();
      st  = (t < 31) ? 4'b0100 : 4'b0000;
      rel = (t == 31) ? 4'b0100 : 4'b0000;
      rep = (t >= 10 && t <= 28 && (t % 3) == 1) ? 4'b0100 : 4'b0000;
      exp = {st, 4'b0000, rel, rep};
      obs = {stateOut, pressPulse, releasePulse, repeatPulse};
      vectors++;
      if (obs !== exp) begin
        $display("FAIL repeat_train t=%0d got=%h want=%h", t, obs, exp);
        miscompares++;
      end
      if (t == 25) asyncIn = 4'hF;
    end
  endtask

  task automatic test_simultaneous();
    logic [15:0] obs, exp;
    logic [3:0]  st, rel, rep;
    asyncIn = 4'b0110;
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp = (k == 6) ? {4'b1001, 4'b1001, 4'b0000, 4'b0000} : 16'h0000;
      obs = {stateOut, pressPulse, releasePulse, repeatPulse};
      vectors++;
      if (obs !== exp) begin
        $display("FAIL dual_press k=%0d got=%h want=%h", k, obs, exp);
        miscompares++;
      end
    end
    for (int t = 1; t <= 16; t++) begin
      tick();
      st  = (t < 10) ? 4'b1001 : 4'b0001;
      rel = (t == 10) ? 4'b1000 : 4'b0000;
      rep = (t >= 10 && ((t - 10) % 3) == 0) ? 4'b0001 : 4'b0000;
      exp = {st, 4'b0000, rel, rep};
      obs = {stateOut, pressPulse, releasePulse, repeatPulse};
      vectors++;
      if (obs !== exp) begin
        $display("FAIL dual_channels t=%0d got=%h want=%h", t, obs, exp);
        miscompares++;
      end
      if (t == 4) asyncIn = 4'b1110;
    end
    asyncIn = 4'hF;
    for (int k = 0; k < 12; k++) tick();
    obs = {stateOut, pressPulse, releasePulse, repeatPulse};
    vectors++;
    if (obs !== 16'h0000) begin
      $display("FAIL dual_settle got=%h want=%h", obs, 16'h0000);
      miscompares++;
    end
  endtask

  task automatic test_reset_mid_repeat();
    logic [15:0] obs, exp;
    asyncIn = 4'b1110;
    for (int k = 1; k <= 6; k++) tick();
    obs = {stateOut, pressPulse, releasePulse, repeatPulse};
    vectors++;
    if (obs !== {4'b0001, 4'b0001, 4'b0000, 4'b0000}) begin
      $display("FAIL midrst_press got=%h want=%h", obs, {4'b0001, 4'b0001, 8'h00});
      miscompares++;
    end
    // Now 12 cycles past the press: in REPEAT, next pulse due at press+13.
    for (int k = 0; k < 12; k++) tick();
    reset_n = 1'b0;
    for (int k = 0; k < 2; k++) begin
      tick();
      obs = {stateOut, pressPulse, releasePulse, repeatPulse};
      vectors++;
      if (obs !== 16'h0000) begin
        $display("FAIL midrst_clear k=%0d got=%h want=%h", k, obs, 16'h0000);
        miscompares++;
      end
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      exp = (k == 6) ? {4'b0001, 4'b0001, 4'b0000, 4'b0000} : 16'h0000;
      obs = {stateOut, pressPulse, releasePulse, repeatPulse};
      vectors++;
      if (obs !== exp) begin
        $display("FAIL midrst_repress k=%0d got=%h want=%h", k, obs, exp);
        miscompares++;
      end
    end
    for (int t = 1; t <= 10; t++) begin
      tick();
      exp = {4'b0001, 4'b0000, 4'b0000, (t == 10) ? 4'b0001 : 4'b0000};
      obs = {stateOut, pressPulse, releasePulse, repeatPulse};
      vectors++;
      if (obs !== exp) begin
        $display("FAIL midrst_repeat t=%0d got=%h want=%h", t, obs, exp);
        miscompares++;
      end
    end
    asyncIn = 4'hF;
    for (int k = 0; k < 8; k++) tick();
    obs = {stateOut, pressPulse, releasePulse, repeatPulse};
    vectors++;
    if (obs !== 16'h0000) begin
      $display("FAIL midrst_settle got=%h want=%h", obs, 16'h0000);
      miscompares++;
    end
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    reset_n     = 1'b0;
    asyncIn     = 4'b0000;
    test_reset();
    test_press_release();
    test_glitch();
    test_repeat();
    test_simultaneous();
    test_reset_mid_repeat();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
